// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Parametrised single-clock FIFO with an exact occupancy count,
//   almost-full/almost-empty thresholds and registered read data marked
//   by a one-cycle VALID strobe.
//
//   Optional feature macro: FIFO_ERR_EN
//     defined   -> sticky OVERFLOW / UNDERFLOW ports and logic are present
//     undefined -> those ports are absent; illegal requests are ignored silently
//
//   Handshake: WR and RD are plain requests with no back-pressure other than
//   the status flags.
//     - A write is taken on a rising edge where EN=1, WR=1 and FULL=0.
//     - A read is taken on a rising edge where EN=1, RD=1 and EMPTY=0.
//     - Both are judged on the flags as they stand before the edge.
//     - VALID is high for exactly the one cycle after a taken read, and in
//       that cycle dataOut holds the word that was read.
//
//   Ports
//     Clk, Rst              clock (rising edge); synchronous active-high reset
//     EN                    global enable; low freezes all state, VALID=0
//     WR, dataIn            write request and data
//     RD                    read request
//     dataOut, VALID        registered read data and its one-cycle strobe
//     EMPTY, FULL           Count == 0 / Count == DEPTH
//     ALMOST_EMPTY          Count <= AE_LEVEL
//     ALMOST_FULL           Count >= AF_LEVEL
//     Count                 occupancy 0..DEPTH
//     OVERFLOW, UNDERFLOW   sticky error flags (FIFO_ERR_EN only)
module sync_fifo_param #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     EN,
   input  logic                     WR,
   input  logic [WIDTH-1:0]         dataIn,
   input  logic                     RD,
   output logic [WIDTH-1:0]         dataOut,
   output logic                     VALID,
   output logic                     EMPTY,
   output logic                     FULL,
   output logic                     ALMOST_EMPTY,
   output logic                     ALMOST_FULL,
   output logic [$clog2(DEPTH):0]   Count
`ifdef FIFO_ERR_EN
   ,
   output logic                     OVERFLOW,
   output logic                     UNDERFLOW
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             wr_ok;
   logic             rd_ok;

   // Flags come straight from the registered count, so they change in the
   // same cycle as Count.
   assign EMPTY        = (count_q == '0);
   assign FULL         = (count_q == DEPTH_C);
   assign ALMOST_EMPTY = (count_q <= AE_C);
   assign ALMOST_FULL  = (count_q >= AF_C);
   assign Count        = count_q;

   assign wr_ok = EN & WR & ~FULL;
   assign rd_ok = EN & RD & ~EMPTY;

   // Storage is never cleared; after a reset the pointers make old words
   // unreachable.
   always_ff @(posedge Clk) begin
      if (!Rst && wr_ok) begin
         mem[wr_ptr] <= dataIn;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         dataOut <= '0;
         VALID   <= 1'b0;
      end else begin
         // rd_ok already contains EN, so VALID drops to 0 while disabled.
         VALID <= rd_ok;
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr  <= rd_ptr + AW'(1);
            dataOut <= mem[rd_ptr];
         end
         // A write and a read taken on the same edge leave the count unchanged.
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef FIFO_ERR_EN
   always_ff @(posedge Clk) begin
      if (Rst) begin
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else begin
         if (EN && WR && FULL) begin
            OVERFLOW <= 1'b1;
         end
         if (EN && RD && EMPTY) begin
            UNDERFLOW <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
//   Directed bench for sync_fifo_param (WIDTH=32, DEPTH=8, AF=6, AE=2).
//   The driver keeps a reference queue of stored words. It pushes the word
//   expected for each accepted read into exp_q. A monitor pops exp_q one cycle
//   later, when VALID should be high. Occupancy checkpoints use hand-computed
//   counts.
module tb_sync_fifo_param;

   localparam int W = 32;

   logic          Clk;
   logic          Rst;
   logic          EN;
   logic          WR;
   logic [W-1:0]  dataIn;
   logic          RD;
   logic [W-1:0]  dataOut;
   logic          VALID;
   logic          EMPTY;
   logic          FULL;
   logic          ALMOST_EMPTY;
   logic          ALMOST_FULL;
   logic [3:0]    Count;
`ifdef FIFO_ERR_EN
   logic          OVERFLOW;
   logic          UNDERFLOW;
`endif

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  model_q[$];
   bit            ovf_m;
   bit            unf_m;
   bit            mon_en;
   int            n_checks;
   int            n_pass;

   sync_fifo_param #(
      .WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .EN           (EN),
      .WR           (WR),
      .dataIn       (dataIn),
      .RD           (RD),
      .dataOut      (dataOut),
      .VALID        (VALID),
      .EMPTY        (EMPTY),
      .FULL         (FULL),
      .ALMOST_EMPTY (ALMOST_EMPTY),
      .ALMOST_FULL  (ALMOST_FULL),
      .Count        (Count)
`ifdef FIFO_ERR_EN
      ,
      .OVERFLOW     (OVERFLOW),
      .UNDERFLOW    (UNDERFLOW)
`endif
   );

   // ---------------- clock / watchdog ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_state(input string tag, input int c);
      check({tag, "_count"}, W'(Count), W'(c));
      check({tag, "_empty"}, W'(EMPTY), W'(c == 0));
      check({tag, "_full"},  W'(FULL),  W'(c == 8));
      check({tag, "_ae"},    W'(ALMOST_EMPTY), W'(c <= 2));
      check({tag, "_af"},    W'(ALMOST_FULL),  W'(c >= 6));
   endtask

   task automatic check_err(input string tag);
`ifdef FIFO_ERR_EN
      check({tag, "_overflow"},  W'(OVERFLOW),  W'(ovf_m));
      check({tag, "_underflow"}, W'(UNDERFLOW), W'(unf_m));
`else
      check({tag, "_no_err"}, W'(0), W'(ovf_m | unf_m));
`endif
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic en, input logic wr, input logic rd, input logic [W-1:0] din);
      bit rd_acc;
      bit wr_acc;
      @(negedge Clk);
      Rst = 1'b0; EN = en; WR = wr; RD = rd; dataIn = din;
      rd_acc = en && rd && (model_q.size() != 0);
      wr_acc = en && wr && (model_q.size() != 8);
`ifdef FIFO_ERR_EN
      if (en && wr && model_q.size() == 8) ovf_m = 1'b1;
      if (en && rd && model_q.size() == 0) unf_m = 1'b1;
`endif
      if (rd_acc) exp_q.push_back(model_q.pop_front());
      if (wr_acc) model_q.push_back(din);
      @(posedge Clk);
      #1;
      if (rd && !rd_acc) check("valid_on_rejected_rd", W'(VALID), W'(0));
   endtask

   task automatic reset_fifo(input int cycles, input logic en);
      @(negedge Clk);
      Rst = 1'b1; EN = en; WR = 1'b0; RD = 1'b0; dataIn = '0;
      model_q.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
      repeat (cycles) @(posedge Clk);
      #1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always begin
      logic [W-1:0] e;
      @(posedge Clk);
      #1;
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valid_strobe", W'(VALID), W'(1));
            check("read_data", dataOut, e);
         end else if (VALID !== 1'b0) begin
            check("valid_spurious", W'(VALID), W'(0));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0; n_pass = 0; mon_en = 1'b0; ovf_m = 1'b0; unf_m = 1'b0;
      Rst = 1'b1; EN = 1'b1; WR = 1'b0; RD = 1'b0; dataIn = '0;

      // 1: reset state
      reset_fifo(2, 1'b1);
      check_state("rst", 0);
      check("rst_dataout", dataOut, 32'h0);
      check("rst_valid", W'(VALID), W'(0));
      check_err("rst");
      mon_en = 1'b1;
      step(1'b1, 1'b0, 1'b0, '0);

      // 2: fill, overflow attempt, drain
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0, W'(i));
         if (i == 4) check_state("fill5", 5);
         if (i == 5) check_state("fill6", 6);
      end
      check_state("full8", 8);
      step(1'b1, 1'b1, 1'b0, 32'hDEAD);
      check_state("ovf_try", 8);
      check_err("ovf_try");
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      check_state("drain1", 0);
      check("drain1_hold", dataOut, 32'h7);

      // 3: pointer wrap
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h100 + W'(i));
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, '0);
      check_state("wrap_mid", 2);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h200 + W'(i));
      check_state("wrap_full", 8);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      check_state("wrap_drain", 0);

      // 4: simultaneous read and write
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h300 + W'(i));
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b1, 32'h400 + W'(i));
         check_state("rw_mid", 4);
      end
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      check_state("rw_drain", 0);
      step(1'b1, 1'b1, 1'b1, 32'h500);
      check_state("rw_empty", 1);
      check("rw_empty_valid", W'(VALID), W'(0));
      for (int i = 1; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h500 + W'(i));
      check_state("rw_fill", 8);
      step(1'b1, 1'b1, 1'b1, 32'hBAD);
      check_state("rw_full", 7);
      check_err("rw_full");
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      check_state("rw_full_drain", 0);

      // 5: enable low freezes everything
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h600 + W'(i));
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, 32'h700 + W'(i));
         check_state("en0", 3);
         check("en0_dataout", dataOut, 32'h507);
         check("en0_valid", W'(VALID), W'(0));
      end

      // 6: reset mid-stream (EN low shows reset wins), then read on empty
      for (int i = 3; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h600 + W'(i));
      check_state("pre_rst", 5);
      reset_fifo(1, 1'b0);
      check_state("mid_rst", 0);
      check("mid_rst_dataout", dataOut, 32'h0);
      check_err("mid_rst");
      step(1'b1, 1'b0, 1'b1, '0);
      check_state("post_rst_rd", 0);
      check_err("post_rst_rd");
      step(1'b1, 1'b0, 1'b0, '0);

      check("exp_q_drained", W'(exp_q.size()), W'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
